// File: rtl/quant_arbiter.sv
// quant_arbiter: round-robin burst arbiter sharing one Q18.16 -> Q8.8 quantizer.
// Optional saturating overflow-beat counter enabled by defining QUANT_OVF_CNT_EN.

module Quantization #(
    parameter int IN_INT_W  = 18,
    parameter int IN_DEC_W  = 16,
    parameter int OUT_INT_W = 8,
    parameter int OUT_DEC_W = 8
) (
    input  logic [IN_INT_W+IN_DEC_W-1:0]   i_data,
    output logic [OUT_INT_W+OUT_DEC_W-1:0] o_data
);
    localparam int IN_W = IN_INT_W + IN_DEC_W;

    // Keep the low integer bits and the high fraction bits.
    assign o_data = {i_data[IN_DEC_W +: OUT_INT_W],
                     i_data[IN_DEC_W-1 -: OUT_DEC_W]};

    logic w_unused;
    assign w_unused = ^{i_data[IN_W-1:IN_DEC_W+OUT_INT_W],
                        i_data[IN_DEC_W-OUT_DEC_W-1:0]};
endmodule

module quant_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int BURST_LEN = 8,
    parameter int IN_INT_W  = 18,
    parameter int IN_DEC_W  = 16,
    parameter int OUT_INT_W = 8,
    parameter int OUT_DEC_W = 8,
    localparam int IN_W  = IN_INT_W + IN_DEC_W,
    localparam int OUT_W = OUT_INT_W + OUT_DEC_W,
    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*IN_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]      req_last,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    out_valid,
    output logic [OUT_W-1:0]        out_data,
    output logic [ID_W-1:0]         out_id,
    output logic                    out_last,
    input  logic                    out_ready
`ifdef QUANT_OVF_CNT_EN
    ,
    output logic [15:0]             ovf_count
`endif
);
    typedef enum logic {IDLE, BURST} state_t;

    state_t           r_state;
    logic [ID_W-1:0]  r_grant;
    logic [ID_W-1:0]  r_rr_ptr;
    logic [7:0]       r_beat_cnt;
    logic             r_out_valid;
    logic [OUT_W-1:0] r_out_data;
    logic [ID_W-1:0]  r_out_id;
    logic             r_out_last;

    logic [IN_W-1:0]  w_data_arr [NUM_REQ];
    logic [IN_W-1:0]  w_gdata;
    logic [OUT_W-1:0] w_qdata;
    logic             w_gvalid;
    logic             w_glast;
    logic             w_ready;
    logic             w_accept;
    logic             w_end;
    logic             w_found;
    logic [ID_W-1:0]  w_pick;
    logic [ID_W-1:0]  w_idx;
    logic [ID_W-1:0]  w_next_ptr;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            w_data_arr[i] = req_data[i*IN_W +: IN_W];
        end
    end

    assign w_gdata  = w_data_arr[r_grant];
    assign w_gvalid = req_valid[r_grant];
    assign w_glast  = req_last[r_grant];
    assign w_ready  = (r_state == BURST) & (out_ready | ~r_out_valid);
    assign w_accept = w_ready & w_gvalid;

    // Burst closes on last, on the beat budget, or when the grantee goes idle.
    assign w_end = (w_accept & (w_glast | (r_beat_cnt == 8'(BURST_LEN-1))))
                 | (w_ready & ~w_gvalid);

    assign w_next_ptr = (r_grant == ID_W'(NUM_REQ-1)) ? '0 : r_grant + 1'b1;

    always_comb begin
        req_ready = '0;
        if (w_ready) begin
            req_ready[r_grant] = 1'b1;
        end
    end

    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = ID_W'((int'(r_rr_ptr) + i) % NUM_REQ);
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    Quantization #(
        .IN_INT_W (IN_INT_W),
        .IN_DEC_W (IN_DEC_W),
        .OUT_INT_W(OUT_INT_W),
        .OUT_DEC_W(OUT_DEC_W)
    ) u_quant (
        .i_data(w_gdata),
        .o_data(w_qdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_grant     <= '0;
            r_rr_ptr    <= '0;
            r_beat_cnt  <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_id    <= '0;
            r_out_last  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_qdata;
                r_out_id    <= r_grant;
                r_out_last  <= w_glast;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            unique case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_grant    <= w_pick;
                        r_beat_cnt <= '0;
                        r_state    <= BURST;
                    end
                end
                BURST: begin
                    if (w_accept) begin
                        r_beat_cnt <= r_beat_cnt + 8'd1;
                    end
                    if (w_end) begin
                        r_rr_ptr <= w_next_ptr;
                        r_state  <= IDLE;
                    end
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_id    = r_out_id;
    assign out_last  = r_out_last;

`ifdef QUANT_OVF_CNT_EN
    logic        w_ovf;
    logic [15:0] r_ovf_count;

    assign w_ovf = |w_gdata[IN_W-1:IN_DEC_W+OUT_INT_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf_count <= '0;
        end else if (w_accept && w_ovf && (r_ovf_count != 16'hFFFF)) begin
            r_ovf_count <= r_ovf_count + 16'd1;
        end
    end

    assign ovf_count = r_ovf_count;
`endif
endmodule

// File: tb/tb_quant_arbiter.sv
// tb_quant_arbiter: directed and randomized checks of quant_arbiter
// against a transaction-level scoreboard of accepted beats.

module tb_quant_arbiter;
    localparam int NR    = 4;
    localparam int BL    = 8;
    localparam int IN_W  = 34;
    localparam int OUT_W = 16;
    localparam int ID_W  = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR-1:0]     req_last = '0;
    logic [NR-1:0]     req_ready;
    logic [NR*IN_W-1:0] req_data = '0;
    logic              out_valid;
    logic              out_last;
    logic              out_ready = 1'b1;
    logic [OUT_W-1:0]  out_data;
    logic [ID_W-1:0]   out_id;
`ifdef QUANT_OVF_CNT_EN
    logic [15:0]       ovf_count;
`endif

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [IN_W-1:0] data;
        logic            last;
    } beat_t;

    beat_t q[$];

    always #5 clk = ~clk;

    quant_arbiter #(.NUM_REQ(NR), .BURST_LEN(BL)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_last (req_last),
        .req_ready(req_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_id   (out_id),
        .out_last (out_last),
        .out_ready(out_ready)
`ifdef QUANT_OVF_CNT_EN
        ,
        .ovf_count(ovf_count)
`endif
    );

    // Q8.8 value = integer part mod 256, then top 8 fraction bits.
    function automatic logic [OUT_W-1:0] quant(input logic [IN_W-1:0] d);
        longint v;
        v = longint'(d);
        return OUT_W'(((v / 65536) % 256) * 256 + ((v / 256) % 256));
    endfunction

    function automatic logic [IN_W-1:0] rnd34();
        return IN_W'({$urandom(), $urandom()});
    endfunction

    task automatic apply_reset();
        req_valid = '0;
        req_last  = '0;
        out_ready = 1'b1;
        rst_n     = 1'b0;
        q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL rst_out_valid got %b want 0", out_valid);
        end
        checks++;
        if (out_data !== '0) begin
            failures++; $display("FAIL rst_out_data got %h want 0", out_data);
        end
        checks++;
        if (out_id !== '0) begin
            failures++; $display("FAIL rst_out_id got %h want 0", out_id);
        end
        checks++;
        if (out_last !== 1'b0) begin
            failures++; $display("FAIL rst_out_last got %b want 0", out_last);
        end
        checks++;
        if (req_ready !== '0) begin
            failures++; $display("FAIL rst_req_ready got %b want 0", req_ready);
        end
`ifdef QUANT_OVF_CNT_EN
        checks++;
        if (ovf_count !== 16'd0) begin
            failures++; $display("FAIL rst_ovf got %0d want 0", ovf_count);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        apply_reset();
        req_data[0 +: IN_W] = {18'd180, 16'h8000};
        req_last  = 4'b0001;
        req_valid = 4'b0001;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++; $display("FAIL single_grant got %b want 0001", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        req_last  = '0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'hB480) begin
            failures++;
            $display("FAIL single_data got v=%b %h want v=1 b480", out_valid, out_data);
        end
        checks++;
        if (out_id !== 2'd0 || out_last !== 1'b1) begin
            failures++;
            $display("FAIL single_tag got id=%0d last=%b want id=0 last=1", out_id, out_last);
        end
        checks++;
        if (req_ready !== '0) begin
            failures++; $display("FAIL single_idle got %b want 0", req_ready);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || req_ready !== '0) begin
            failures++;
            $display("FAIL single_drain got v=%b rdy=%b want 0 0", out_valid, req_ready);
        end
    endtask

    task automatic test_rotation();
        logic [IN_W-1:0] dat [NR];
        int n, bubbles, cyc, eid;
        bit started;
        apply_reset();
        for (int i = 0; i < NR; i++) begin
            dat[i] = rnd34();
            req_data[i*IN_W +: IN_W] = dat[i];
        end
        req_valid = '1;
        n = 0; bubbles = 0; cyc = 0; started = 0;
        while (n < 40 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (out_valid) begin
                eid = (n / BL) % NR;
                checks++;
                if (out_id !== ID_W'(eid) || out_data !== quant(dat[eid])) begin
                    failures++;
                    $display("FAIL rot_beat%0d got id=%0d %h want id=%0d %h",
                             n, out_id, out_data, eid, quant(dat[eid]));
                end
                started = 1;
                n++;
            end else if (started) begin
                bubbles++;
            end
        end
        req_valid = '0;
        checks++;
        if (n != 40) begin
            failures++; $display("FAIL rot_count got %0d want 40", n);
        end
        checks++;
        if (bubbles != 4) begin
            failures++; $display("FAIL rot_bubbles got %0d want 4", bubbles);
        end
    endtask

    task automatic test_backpressure();
        logic [IN_W-1:0] d;
        beat_t b;
        int sent, got, cyc, stall_left;
        bit stalled, adv, held;
        apply_reset();
        d = rnd34();
        sent = 0; got = 0; cyc = 0; stall_left = 0;
        stalled = 0; adv = 0; held = 0;
        while (got < 12 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (held) begin
                checks++;
                if (out_valid !== 1'b1) begin
                    failures++; $display("FAIL bp_hold_valid got %b want 1", out_valid);
                end
            end
            if (out_valid) begin
                checks++;
                if (q.size() == 0) begin
                    failures++; $display("FAIL bp_spurious got id=%0d want none", out_id);
                end else if (out_data !== quant(q[0].data) || out_id !== 2'd2) begin
                    failures++;
                    $display("FAIL bp_data got id=%0d %h want id=2 %h",
                             out_id, out_data, quant(q[0].data));
                end
            end
            if (adv) begin
                d = rnd34();
                adv = 0;
            end
            if (got == 3 && !stalled) begin
                stall_left = 5;
                stalled = 1;
            end
            out_ready = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            req_data[2*IN_W +: IN_W] = d;
            req_valid = (sent < 12) ? 4'b0100 : 4'b0000;
            #1;
            held = out_valid && !out_ready;
            if (held) begin
                checks++;
                if (req_ready !== '0) begin
                    failures++; $display("FAIL bp_ready got %b want 0", req_ready);
                end
            end
            if (out_valid && out_ready && q.size() > 0) begin
                void'(q.pop_front());
                got++;
            end
            if (req_valid[2] && req_ready[2]) begin
                b.id = 2'd2; b.data = d; b.last = 1'b0;
                q.push_back(b);
                sent++;
                adv = 1;
            end
        end
        req_valid = '0;
        out_ready = 1'b1;
        checks++;
        if (got != 12 || q.size() != 0) begin
            failures++; $display("FAIL bp_total got %0d left %0d want 12 0", got, q.size());
        end
    endtask

    task automatic test_wrap();
        int ids[$];
        int cyc;
        apply_reset();
        req_data[2*IN_W +: IN_W] = rnd34();
        req_valid = 4'b0100;
        req_last  = 4'b0100;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_id !== 2'd2) begin
            failures++; $display("FAIL wrap_setup got v=%b id=%0d want 1 2", out_valid, out_id);
        end
        req_data[1*IN_W +: IN_W] = rnd34();
        req_data[3*IN_W +: IN_W] = rnd34();
        req_valid = 4'b1010;
        req_last  = 4'b1010;
        cyc = 0;
        while (ids.size() < 2 && cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (out_valid) ids.push_back(int'(out_id));
        end
        req_valid = '0;
        req_last  = '0;
        checks++;
        if (ids.size() != 2) begin
            failures++; $display("FAIL wrap_count got %0d want 2", ids.size());
        end else begin
            checks++;
            if (ids[0] != 3 || ids[1] != 1) begin
                failures++; $display("FAIL wrap_order got %0d,%0d want 3,1", ids[0], ids[1]);
            end
        end
    endtask

    task automatic test_random();
        logic [IN_W-1:0] dv [NR];
        beat_t b;
        int cyc;
        apply_reset();
        for (cyc = 0; cyc < 650; cyc++) begin
            @(negedge clk);
            if (out_valid) begin
                checks++;
                if (q.size() == 0) begin
                    failures++; $display("FAIL rnd_spurious got id=%0d want none", out_id);
                end else if (out_data !== quant(q[0].data) || out_id !== q[0].id
                             || out_last !== q[0].last) begin
                    failures++;
                    $display("FAIL rnd_beat got id=%0d %h l=%b want id=%0d %h l=%b",
                             out_id, out_data, out_last,
                             q[0].id, quant(q[0].data), q[0].last);
                end
            end
            if (cyc < 600) begin
                for (int i = 0; i < NR; i++) begin
                    dv[i] = rnd34();
                    req_data[i*IN_W +: IN_W] = dv[i];
                    req_valid[i] = ($urandom_range(3) != 0);
                    req_last[i]  = ($urandom_range(5) == 0);
                end
                out_ready = ($urandom_range(2) != 0);
            end else begin
                req_valid = '0;
                out_ready = 1'b1;
            end
            #1;
            checks++;
            if ($countones(req_ready) > 1 || (out_valid && !out_ready && req_ready != '0)) begin
                failures++;
                $display("FAIL rnd_ready got %b want onehot0, 0 when stalled", req_ready);
            end
            if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
            for (int i = 0; i < NR; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    b.id = ID_W'(i); b.data = dv[i]; b.last = req_last[i];
                    q.push_back(b);
                end
            end
        end
        checks++;
        if (q.size() != 0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rnd_drain got left=%0d v=%b want 0 0", q.size(), out_valid);
        end
    endtask

    task automatic test_ovf_and_async_reset();
        int k, cyc;
        bit acc;
        apply_reset();
        req_valid = 4'b0001;
        k = 0; cyc = 0;
        while (k < 5 && cyc < 100) begin
            req_data[0 +: IN_W] = {(k < 3) ? 18'd300 : 18'd5, 16'(k * 4099)};
            req_last = (k == 4) ? 4'b0001 : 4'b0000;
            #1;
            acc = req_ready[0];
            @(negedge clk);
            cyc++;
            if (acc) k++;
        end
        req_valid = '0;
        req_last  = '0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (k != 5) begin
            failures++; $display("FAIL ovf_beats got %0d want 5", k);
        end
`ifdef QUANT_OVF_CNT_EN
        checks++;
        if (ovf_count !== 16'd3) begin
            failures++; $display("FAIL ovf_count got %0d want 3", ovf_count);
        end
`endif
        req_data[0 +: IN_W] = {18'd300, 16'hC000};
        req_valid = 4'b0001;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h2CC0) begin
            failures++;
            $display("FAIL arst_pre got v=%b %h want 1 2cc0", out_valid, out_data);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_id !== '0 || out_last !== 1'b0) begin
            failures++;
            $display("FAIL arst_out got v=%b %h id=%0d l=%b want all 0",
                     out_valid, out_data, out_id, out_last);
        end
        checks++;
        if (req_ready !== '0) begin
            failures++; $display("FAIL arst_ready got %b want 0", req_ready);
        end
`ifdef QUANT_OVF_CNT_EN
        checks++;
        if (ovf_count !== 16'd0) begin
            failures++; $display("FAIL arst_ovf got %0d want 0", ovf_count);
        end
`endif
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_backpressure();
        test_wrap();
        test_random();
        test_ovf_and_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/quant_arbiter.md
# quant_arbiter

Round-robin arbiter and sequencer that shares one combinational `Quantization` instance among `NUM_REQ` requesters (attention heads / matmul accumulators). It converts Q18.16 accumulator words to Q8.8 and returns each result through a single registered, tagged output stream. Grants are held for bursts of up to `BURST_LEN` beats so a requester's vector stays contiguous downstream. An optional overflow statistics counter is included.

## Interface

- `NUM_REQ`, 4, number of requesters (2..8)
- `BURST_LEN`, 8, maximum consecutive beats granted to one requester (1..255)
- `IN_INT_W`, 18, input integer bits (passed to `Quantization`)
- `IN_DEC_W`, 16, input fractional bits
- `OUT_INT_W`, 8, output integer bits
- `OUT_DEC_W`, 8, output fractional bits
- Derived: `IN_W = IN_INT_W+IN_DEC_W` (34), `OUT_W = OUT_INT_W+OUT_DEC_W` (16), `ID_W = clog2(NUM_REQ)` (min 1)

Ports:

- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `req_valid`  in  NUM_REQ  per-requester data valid
- `req_data`  in  NUM_REQ*IN_W  packed; requester i occupies bits [i*IN_W +: IN_W]
- `req_last`  in  NUM_REQ  per-requester end-of-vector marker
- `req_ready`  out  NUM_REQ  one-hot or zero; beat accepted when valid&ready
- `out_valid`  out  1  result valid
- `out_data`  out  OUT_W  quantized value
- `out_id`  out  ID_W  source requester index
- `out_last`  out  1  registered copy of the accepted `req_last`
- `out_ready`  in  1  downstream accept
- `ovf_count`  out  16  overflow beat counter (QUANT_OVF_CNT_EN only)

## Operation

- FSM states: `IDLE`, `BURST`.
- `IDLE`: when any `req_valid` is set, grant the first valid requester at or after `rr_ptr`, searching upward with wrap. Load `beat_cnt=0` and go to `BURST`. Grant selection is registered; `req_ready` is never asserted in `IDLE`.
- `BURST`: `req_ready[grant] = out_ready | ~out_valid`. Accepting a beat:
  - drives `req_data[grant]` through `Quantization`;
  - registers the result into `out_data`, `grant` into `out_id`, and `req_last[grant]` into `out_last`;
  - sets `out_valid` and increments `beat_cnt`.
- The burst ends, going to `IDLE` with `rr_ptr = grant+1` (wraps `NUM_REQ-1 -> 0`), on any of:
  - an accepted beat with `req_last`;
  - `beat_cnt` reaching `BURST_LEN`;
  - the granted requester dropping `req_valid` while `req_ready` is high.
- `out_valid` clears on `out_ready` when no new beat is accepted in the same cycle.
- Simultaneous pop and push: the output register is replaced and `out_valid` stays 1.
- The datapath is unmodified `Quantization` output, with no extra rounding in this block.
- Overflow: a beat is an overflow when `req_data[grant][IN_W-1 : IN_DEC_W+OUT_INT_W]` is nonzero, i.e. the integer part exceeds 8 unsigned bits.

## Timing

- Reset values: `out_valid=0`, `out_data=0`, `out_id=0`, `out_last=0`, `req_ready=0`, `rr_ptr=0`, `beat_cnt=0`, state `IDLE`, `ovf_count=0`.
- Arbitration overhead is 1 cycle in `IDLE` per burst. Accepted-beat-to-`out_valid` latency is 1 cycle.
- Throughput within a burst is 1 beat/cycle with `out_ready` held high. Bursts are separated by one `IDLE` cycle.
- Backpressure: with `out_valid=1` and `out_ready=0`, `req_ready=0` and the output registers are held stable.
- A `req_valid` drop mid-burst costs no beat. A requester raising `req_valid` during another's burst waits for the rotation.
- Reset asserted mid-burst clears everything immediately. Any in-flight output is discarded.

## Configuration

- `QUANT_OVF_CNT_EN` defined:
  - `ovf_count` increments on each accepted overflow beat and saturates at 16'hFFFF.
  - The port exists.
- Not defined: the port and counter logic are absent, and overflow detection is not synthesized.

## Test plan

- Single requester 0 sends `{18'd180, 16'h8000}` with `req_last=1` -> one cycle later `out_data=16'hB480` (180.5), `out_id=0`, `out_last=1`; FSM returns to `IDLE`.
- All 4 requesters continuously valid, no `last`, `BURST_LEN=8`, `out_ready=1` -> output `out_id` sequence is 8x0, 8x1, 8x2, 8x3, 8x0, with one bubble cycle between bursts.
- Requester 2 mid-burst, `out_ready` low for 5 cycles -> `req_ready=0`; `out_data` and `out_id` hold; no beat lost or duplicated after release.
- `rr_ptr=3`, only requesters 1 and 3 valid -> 3 granted first, then 1 (wrap).
- `QUANT_OVF_CNT_EN`: 3 beats with integer part 18'd300, then 2 beats with integer part 18'd5 -> `ovf_count=3`; assert `rst_n` mid-burst -> all outputs 0 asynchronously and `ovf_count=0`.
